// File: rtl/pcileech_pkg.sv
// Shared constants and types for the pcileech FT601 output path.
// No logic; types and values only.
// Not applicable (package).
package pcileech_pkg;

   // FTDI transfer-termination workaround: magic pad DWORD and group size
   localparam logic [31:0] PCILEECH_FTDI_MAGIC     = 32'h66665555;
   localparam int          PCILEECH_FTDI_PAD_COUNT = 5;

   // TX packer control state
   typedef enum logic [1:0] {
      TXPACK_IDLE = 2'd0,
      TXPACK_DATA = 2'd1,
      TXPACK_PAD  = 2'd2
   } txpack_state_t;

endpackage

// File: rtl/pcileech_ft601_txpack.sv
// 256->32 TX packer: eight DWORDs per accepted word (low first), plus atomic magic pad groups when idle.
// Latency: word accepted on edge N, DWORD k registered on edge N+1+k (one DWORD per clock, no gap between words).
// Backpressure: dout_almost_full freezes emission (dout_valid=0, idx/pcnt hold); din_ready only in IDLE or on the final unstalled DWORD.
module pcileech_ft601_txpack
   import pcileech_pkg::*;
#(
   parameter int          PARAM_PAD_COUNT = PCILEECH_FTDI_PAD_COUNT,  // 1..15
   parameter logic [31:0] PARAM_MAGIC     = PCILEECH_FTDI_MAGIC
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic [31:0]  dout,
   output logic         dout_valid,
   input  logic         dout_almost_full,
   input  logic         fifo_prog_empty,
   input  logic         ft601_txe_n,
   output logic [15:0]  pad_groups
);

   localparam logic [3:0] PAD_LAST = 4'(PARAM_PAD_COUNT - 1);

   txpack_state_t state;
   logic [255:0]  hold;
   logic [2:0]    idx;
   logic [3:0]    pcnt;
   logic          stall;
   logic          word_last;

   // The deep FIFO's threshold leaves >=2 free slots, so reacting on the same edge is safe
   assign stall = dout_almost_full;

   // Last DWORD of the held word goes out this cycle, so a new word may be loaded behind it
   assign word_last = (state == TXPACK_DATA) && (idx == 3'd7) && !stall;

   // Ready is never asserted mid-word or mid-pad-group; pad groups are atomic
   assign din_ready = (state == TXPACK_IDLE) || word_last;

   // Control FSM with registered DWORD output, hold register and pad-group counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= TXPACK_IDLE;
         hold       <= '0;
         idx        <= 3'd0;
         pcnt       <= 4'd0;
         dout       <= 32'd0;
         dout_valid <= 1'b0;
         pad_groups <= 16'd0;
      end else begin
         dout_valid <= 1'b0;
         unique case (state)
            TXPACK_IDLE: begin
               // data wins over pad when both are possible
               if (din_valid) begin
                  hold  <= din;
                  idx   <= 3'd0;
                  state <= TXPACK_DATA;
               end else if (fifo_prog_empty && ft601_txe_n) begin
                  pcnt  <= 4'd0;
                  state <= TXPACK_PAD;
               end
            end
            TXPACK_DATA: begin
               if (!stall) begin
                  dout       <= hold[{idx, 5'd0} +: 32];
                  dout_valid <= 1'b1;
                  if (idx == 3'd7) begin
                     idx <= 3'd0;
                     // reload behind the last DWORD so consecutive words run without a bubble
                     if (din_valid) begin
                        hold <= din;
                     end else begin
                        state <= TXPACK_IDLE;
                     end
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            TXPACK_PAD: begin
               if (!stall) begin
                  dout       <= PARAM_MAGIC;
                  dout_valid <= 1'b1;
                  pcnt       <= pcnt + 4'd1;
                  if (pcnt == PAD_LAST) begin
                     pad_groups <= pad_groups + 16'd1;
                     state      <= TXPACK_IDLE;
                  end
               end
            end
            default: begin
               state <= TXPACK_IDLE;
            end
         endcase
      end
   end

endmodule
